mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 44 ++++
 rtl/mem_port_arbiter_sat_counter16.sv | 31 +++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings, FSM states and widths for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'b00,
    CS_IN    = 2'b01,
    CS_CHECK = 2'b10,
    CS_RUN   = 2'b11
  } cpustate_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_SWITCH
  } state_e;

  // State the arbiter should settle in for a given CPU mode.
  function automatic state_e target_of(input logic [1:0] cs);
    case (cs)
      CS_IN:    return S_LOAD;
      CS_CHECK: return S_CHECK;
      CS_RUN:   return S_RUN;
      default:  return S_IDLE;
    endcase
  endfunction

  // True when state s is the owner for CPU mode cs; S_SWITCH owns no mode.
  function automatic logic state_matches(input state_e s, input logic [1:0] cs);
    case (s)
      S_IDLE:  return cs == CS_IDLE;
      S_LOAD:  return cs == CS_IN;
      S_CHECK: return cs == CS_CHECK;
      S_RUN:   return cs == CS_RUN;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter16.sv
// rtl/mem_port_arbiter_sat_counter16.sv - 16-bit saturating counter with synchronous clear
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - load zero on the next edge (wins over inc)
//   inc       - count up by one, sticking at all-ones
//   q         - current count
module sat_counter16
  import mem_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clear) begin
      r_q <= '0;
    end else if (inc && (r_q != {CNT_W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - hands the single synchronous RAM port to loader, checker or CPU by CPU mode
// Ports:
//   clk, rst                         - clock, asynchronous active-high reset
//   cpustate                         - CPU mode 00 IDLE / 01 IN / 10 CHECK / 11 RUN
//   ld_req/ld_addr/ld_wdata/ld_gnt   - loader write channel (granted in IN)
//   ck_req/ck_addr/ck_gnt            - checker read request (granted in CHECK)
//   ck_valid/ck_rdata                - checker read data, one cycle after ck_gnt
//   cpu_read/cpu_write/cpu_addr/
//   cpu_wdata/cpu_rdata/cpu_ready    - CPU pass-through (RUN)
//   mem_rd/mem_wr/mem_addr/
//   mem_wdata/mem_rdata              - RAM port, read data one cycle after mem_rd
//   ld_count                         - saturating count of writes in the current IN session
//   illegal_req                      - sticky flag for requests made outside their owning mode
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cpustate,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  input  logic              ck_req,
  input  logic [ADDR_W-1:0] ck_addr,
  output logic              ck_gnt,
  output logic              ck_valid,
  output logic [DATA_W-1:0] ck_rdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  ld_count,
  output logic              illegal_req
);

  state_e     r_state;
  state_e     w_state_nx;
  logic [1:0] r_cs_prev;
  logic       r_rd_pending;
  logic       r_illegal;

  logic w_match;
  logic w_own;
  logic w_cs_changed;
  logic w_in_load;
  logic w_in_check;
  logic w_in_run;
  logic w_illegal_set;
  logic w_cnt_clear;

  assign w_in_load    = (r_state == S_LOAD);
  assign w_in_check   = (r_state == S_CHECK);
  assign w_in_run     = (r_state == S_RUN);
  assign w_match      = state_matches(r_state, cpustate);
  // A mode change is only trusted once it has been stable for a cycle, so
  // nothing is granted on the cycle cpustate moves.
  assign w_cs_changed = (cpustate != r_cs_prev);
  assign w_own        = w_match && !w_cs_changed;

  always_comb begin
    w_state_nx = r_state;
    ld_gnt     = 1'b0;
    ck_gnt     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;

    case (r_state)
      S_SWITCH: w_state_nx = target_of(cpustate);
      // Hold CHECK one extra cycle so an in-flight read lands before the
      // port changes hands.
      S_CHECK:  if (!w_match && !r_rd_pending) w_state_nx = S_SWITCH;
      default:  if (!w_match) w_state_nx = S_SWITCH;
    endcase

    case (r_state)
      S_LOAD: begin
        if (w_own && ld_req) begin
          ld_gnt    = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = ld_addr;
          mem_wdata = ld_wdata;
        end
      end
      S_CHECK: begin
        if (w_own && ck_req) begin
          ck_gnt   = 1'b1;
          mem_rd   = 1'b1;
          mem_addr = ck_addr;
        end
      end
      S_RUN: begin
        cpu_ready = 1'b1;
        cpu_rdata = mem_rdata;
        if (w_own) begin
          // A simultaneous read and write keeps only the read.
          mem_rd    = cpu_read;
          mem_wr    = cpu_write && !cpu_read;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
        end
      end
      default: ;
    endcase
  end

  assign w_illegal_set = (ld_req && !w_in_load)
                      || (ck_req && !w_in_check)
                      || ((cpu_read || cpu_write) && !w_in_run)
                      || (w_in_run && cpu_read && cpu_write);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cs_prev    <= CS_IDLE;
      r_rd_pending <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cs_prev    <= cpustate;
      r_rd_pending <= ck_gnt;
      if (w_illegal_set) r_illegal <= 1'b1;
    end
  end

  assign ck_valid    = r_rd_pending;
  assign ck_rdata    = r_rd_pending ? mem_rdata : '0;
  assign illegal_req = r_illegal;

  // Count restarts on the edge that enters LOAD so the first LOAD cycle reads 0.
  assign w_cnt_clear = (r_state != S_LOAD) && (w_state_nx == S_LOAD);

  sat_counter16 u_ld_count (
    .clk   (clk),
    .rst   (rst),
    .clear (w_cnt_clear),
    .inc   (ld_gnt),
    .q     (ld_count)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter against a behavioural model
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  cpustate;
  logic        ld_req, ck_req, cpu_read, cpu_write;
  logic [15:0] ld_addr, ck_addr, cpu_addr;
  logic [7:0]  ld_wdata, cpu_wdata;
  logic [7:0]  mem_rdata;
  logic        ld_gnt, ck_gnt, ck_valid, cpu_ready, mem_rd, mem_wr, illegal_req;
  logic [7:0]  ck_rdata, cpu_rdata, mem_wdata;
  logic [15:0] mem_addr, ld_count;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .cpustate(cpustate),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
    .ck_req(ck_req), .ck_addr(ck_addr), .ck_gnt(ck_gnt), .ck_valid(ck_valid), .ck_rdata(ck_rdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ld_count(ld_count), .illegal_req(illegal_req)
  );

  typedef struct packed {
    logic        ld_gnt, ck_gnt, ck_valid, cpu_ready, mem_rd, mem_wr, illegal;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, ck_rdata, cpu_rdata;
    logic [15:0] ld_count;
  } obs_t;

  obs_t       exp_q[$];
  logic [7:0] rd_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  bit         done  = 1'b0;

  // Synchronous RAM attached to the arbiter's memory port.
  logic [7:0] ram [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_rd) mem_rdata <= ram[mem_addr];
      if (mem_wr) ram[mem_addr] = mem_wdata;
    end
  end

  // Reference model: mode owner, one-deep checker read, memory image.
  logic [7:0] ref_mem [0:65535];
  int         m_st;    // 0 idle, 1 load, 2 check, 3 run, 4 switching
  bit         m_pend;
  logic [1:0] m_prev;
  int         m_cnt;
  bit         m_ill;
  logic [7:0] m_q;

  task automatic cyc(input bit r, input logic [1:0] cs,
                     input bit lr, input logic [15:0] la, input logic [7:0] lw,
                     input bit kr, input logic [15:0] ka,
                     input bit crd, input bit cwr, input logic [15:0] ca, input logic [7:0] cw);
    obs_t e;
    bit   own, lg, kg, rr, ww;
    int   old;
    @(posedge clk);
    #1;
    rst = r; cpustate = cs;
    ld_req = lr; ld_addr = la; ld_wdata = lw;
    ck_req = kr; ck_addr = ka;
    cpu_read = crd; cpu_write = cwr; cpu_addr = ca; cpu_wdata = cw;
    if (r) begin
      m_st = 0; m_pend = 1'b0; m_cnt = 0; m_ill = 1'b0; m_prev = cs;
      rd_q.delete();
      e = '0;
      exp_q.push_back(e);
      return;
    end
    own = (m_st == int'(cs)) && (cs == m_prev);
    lg  = own && (m_st == 1) && lr;
    kg  = own && (m_st == 2) && kr;
    rr  = own && (m_st == 3) && crd;
    ww  = own && (m_st == 3) && cwr && !crd;
    e.ld_gnt    = lg;
    e.ck_gnt    = kg;
    e.ck_valid  = m_pend;
    e.cpu_ready = (m_st == 3);
    e.mem_rd    = kg || rr;
    e.mem_wr    = lg || ww;
    e.illegal   = m_ill;
    e.mem_addr  = lg ? la : kg ? ka : (own && m_st == 3) ? ca : 16'h0;
    e.mem_wdata = lg ? lw : (own && m_st == 3) ? cw : 8'h0;
    e.ck_rdata  = m_pend ? m_q : 8'h0;
    e.cpu_rdata = (m_st == 3) ? m_q : 8'h0;
    e.ld_count  = 16'(m_cnt);
    exp_q.push_back(e);
    if (kg) begin
      rd_q.push_back(ref_mem[ka]);
      m_q = ref_mem[ka];
    end
    if (rr) m_q = ref_mem[ca];
    if (lg) begin
      ref_mem[la] = lw;
      if (m_cnt < 65535) m_cnt++;
    end
    if (ww) ref_mem[ca] = cw;
    if ((lr && m_st != 1) || (kr && m_st != 2) || ((crd || cwr) && m_st != 3) || (m_st == 3 && crd && cwr))
      m_ill = 1'b1;
    old = m_st;
    if (m_st == 4) m_st = int'(cs);
    else if (int'(cs) != m_st && !(m_st == 2 && m_pend)) m_st = 4;
    if (m_st == 1 && old != 1) m_cnt = 0;
    m_pend = kg;
    m_prev = cs;
  endtask

  task automatic idle(input logic [1:0] cs);
    cyc(1'b0, cs, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic ld(input logic [15:0] a);
    cyc(1'b0, 2'b01, 1'b1, a, 8'($urandom), 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  task automatic ck(input logic [15:0] a);
    cyc(1'b0, 2'b10, 1'b0, 16'h0, 8'h0, 1'b1, a, 1'b0, 1'b0, 16'h0, 8'h0);
  endtask

  // Stimulus
  initial begin
    logic [1:0] cs_r;
    bit         b_rd, b_wr;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    m_st = 0; m_pend = 1'b0; m_prev = 2'b00; m_cnt = 0; m_ill = 1'b0; m_q = 8'h00;
    rst = 1'b1; cpustate = 2'b00;
    ld_req = 1'b0; ld_addr = '0; ld_wdata = '0; ck_req = 1'b0; ck_addr = '0;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    cyc(1'b1, 2'b00, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    cyc(1'b1, 2'b00, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    idle(2'b00); idle(2'b00);

    // IN session: switch gap, three writes, then random loader traffic
    idle(2'b01); idle(2'b01);
    for (int i = 0; i < 3; i++) ld(16'(i));
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) ld(16'($urandom_range(0, 31)));
      else idle(2'b01);
    end

    // CHECK session: back-to-back reads, then random reads
    idle(2'b10); idle(2'b10);
    ck(16'h0001); ck(16'h0002);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) ck(16'($urandom_range(0, 31)));
      else idle(2'b10);
    end

    // Mode change right behind a checker read, then CPU traffic
    ck(16'h0003);
    for (int i = 0; i < 4; i++) idle(2'b11);
    for (int i = 0; i < 40; i++) begin
      b_rd = 1'($urandom);
      b_wr = b_rd ? 1'b0 : 1'($urandom);
      cyc(1'b0, 2'b11, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, b_rd, b_wr, 16'($urandom_range(0, 31)), 8'($urandom));
    end

    // Errors in RUN: stray loader request, then read+write together
    cyc(1'b0, 2'b11, 1'b1, 16'h0007, 8'h5A, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    cyc(1'b0, 2'b11, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0005, 8'hA5);
    idle(2'b11); idle(2'b11);

    // Random mode changes and requests
    cs_r = 2'b11;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) cs_r = 2'($urandom);
      cyc(1'b0, cs_r,
          $urandom_range(0, 2) == 0, 16'($urandom_range(0, 31)), 8'($urandom),
          $urandom_range(0, 2) == 0, 16'($urandom_range(0, 31)),
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 16'($urandom_range(0, 31)), 8'($urandom));
    end

    // Saturation of the load counter
    for (int i = 0; i < 4; i++) idle(2'b01);
    for (int i = 0; i < 65537; i++) ld(16'(i));
    idle(2'b01); idle(2'b01);
    for (int i = 0; i < 3; i++) idle(2'b00);

    // Asynchronous reset with a checker read in flight
    for (int i = 0; i < 4; i++) idle(2'b10);
    ck(16'h0001);
    cyc(1'b1, 2'b10, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    cyc(1'b1, 2'b10, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    for (int i = 0; i < 5; i++) idle(2'b10);
    ck(16'h0002);
    idle(2'b10); idle(2'b10);
    done = 1'b1;
  end

  // Monitor: compares every presented cycle and every checker read-data beat.
  initial begin
    obs_t       act, ex;
    logic [7:0] ed;
    forever begin
      @(negedge clk);
      act = {ld_gnt, ck_gnt, ck_valid, cpu_ready, mem_rd, mem_wr, illegal_req,
             mem_addr, mem_wdata, ck_rdata, cpu_rdata, ld_count};
      if (ck_valid === 1'b1) begin
        n_vec++;
        if (rd_q.size() == 0) begin
          n_bad++;
          $display("FAIL ck_data: got ck_valid=1 ck_rdata=%h, required no read outstanding", ck_rdata);
        end else begin
          ed = rd_q.pop_front();
          if (ck_rdata !== ed) begin
            n_bad++;
            $display("FAIL ck_data: got %h, required %h", ck_rdata, ed);
          end
        end
      end
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        n_vec++;
        if (act !== ex) begin
          n_bad++;
          $display("FAIL cycle t=%0t: got gnt=%b%b v=%b rdy=%b rd=%b wr=%b ill=%b a=%h d=%h ckd=%h cpd=%h cnt=%h; required gnt=%b%b v=%b rdy=%b rd=%b wr=%b ill=%b a=%h d=%h ckd=%h cpd=%h cnt=%h",
                   $time, act.ld_gnt, act.ck_gnt, act.ck_valid, act.cpu_ready, act.mem_rd, act.mem_wr, act.illegal,
                   act.mem_addr, act.mem_wdata, act.ck_rdata, act.cpu_rdata, act.ld_count,
                   ex.ld_gnt, ex.ck_gnt, ex.ck_valid, ex.cpu_ready, ex.mem_rd, ex.mem_wr, ex.illegal,
                   ex.mem_addr, ex.mem_wdata, ex.ck_rdata, ex.cpu_rdata, ex.ld_count);
        end
      end
      if (done && exp_q.size() == 0) begin
        n_vec++;
        if (rd_q.size() != 0) begin
          n_bad++;
          $display("FAIL drain: got %0d checker reads never delivered, required 0", rd_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before end of stimulus");
    $fatal(1);
  end

endmodule
